vga_sprite_ctrl: RTL and testbench

Parametrised, button-driven sprite renderer for the VGA pipeline. It replaces the single-pixel, single-button renderer with a rectangular sprite of configurable size, moved by four debounced direction buttons. Motion is applied once per frame, during vertical blanking. The block sits between the VGA timing generator (`sx`, `sy`, `de` on the pixel clock) and the `rgb` output pins, and produces a 2-cycle pipelined 6-bit colour.

---
 rtl/vga_sprite_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vga_sprite_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_ctrl.sv
// vga_sprite_ctrl: button-driven rectangular sprite renderer for the VGA pipeline.
// Four raw buttons {right, left, down, up} are synchronised and debounced. The
// sprite position moves once per frame, on the first pixel of vertical blanking.
// Colour output is a 2-stage pipeline, so rgb lags sx/sy/de by two clocks.
// Optional feature macro: SPRITE_WRAP_EN. When it is defined the position wraps
// around the screen edges. When it is undefined the position clamps to them.
module vga_sprite_ctrl #(
  parameter int         H_RES   = 800,
  parameter int         V_RES   = 480,
  parameter int         CORDW   = 10,
  parameter int         SPR_W   = 16,
  parameter int         SPR_H   = 16,
  parameter int         STEP    = 2,
  parameter int         DB_BITS = 16,
  parameter logic [5:0] FG      = 6'b110000,
  parameter logic [5:0] BG      = 6'b000011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic [3:0]       btn,
  output logic [5:0]       rgb,
  output logic [CORDW-1:0] pos_x,
  output logic [CORDW-1:0] pos_y,
  output logic             moving
);

  // Movement arithmetic is signed and one bit wider than a coordinate, so that
  // stepping below zero shows up as a set sign bit.
  localparam logic signed [CORDW:0] STEP_S = (CORDW+1)'(STEP);
  localparam logic signed [CORDW:0] XMAX_S = (CORDW+1)'(H_RES - SPR_W);
  localparam logic signed [CORDW:0] YMAX_S = (CORDW+1)'(V_RES - SPR_H);
  localparam logic [CORDW-1:0] X_RST = CORDW'((H_RES - SPR_W) / 2);
  localparam logic [CORDW-1:0] Y_RST = CORDW'((V_RES - SPR_H) / 2);
  localparam logic [CORDW:0]   SPR_W_U = (CORDW+1)'(SPR_W);
  localparam logic [CORDW:0]   SPR_H_U = (CORDW+1)'(SPR_H);

  // Button bit positions within btn.
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;

  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         db_q, db_d;
  logic [DB_BITS-1:0] cnt_q [4];
  logic [DB_BITS-1:0] cnt_d [4];

  logic [CORDW-1:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic                 moving_q, moving_d;
  logic                 tick;
  logic signed [CORDW:0] dx_s, dy_s, nx_s, ny_s;

  logic             hit_q, hit_d, de1_q;
  logic [5:0]       rgb_q, rgb_d;
  logic [CORDW-1:0] diff_x, diff_y;

  // Brings one axis back on screen after a step: wraps or clamps, depending on the build.
  function automatic logic signed [CORDW:0] limit_axis(input logic signed [CORDW:0] v,
                                                       input logic signed [CORDW:0] vmax);
`ifdef SPRITE_WRAP_EN
    if (v[CORDW]) return v + vmax + (CORDW+1)'(1);
    else if (v > vmax) return v - vmax - (CORDW+1)'(1);
    return v;
`else
    if (v[CORDW]) return '0;
    else if (v > vmax) return vmax;
    return v;
`endif
  endfunction

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a button adopts a new level only after holding it for 2^DB_BITS clocks.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (&cnt_q[i]) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_BITS'(1);
        end
      end
    end
  end

  // Debounce state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // One-cycle frame tick on the first pixel of the first blanking line.
  assign tick = (sx == '0) && (sy == CORDW'(V_RES));

  // Next position and moving flag. This logic reads the debounced state from before the edge.
  always_comb begin
    dx_s = '0;
    dy_s = '0;
    if (db_q[B_RIGHT] && !db_q[B_LEFT]) dx_s = STEP_S;
    else if (db_q[B_LEFT] && !db_q[B_RIGHT]) dx_s = -STEP_S;
    if (db_q[B_DOWN] && !db_q[B_UP]) dy_s = STEP_S;
    else if (db_q[B_UP] && !db_q[B_DOWN]) dy_s = -STEP_S;
    nx_s     = limit_axis($signed({1'b0, pos_x_q}) + dx_s, XMAX_S);
    ny_s     = limit_axis($signed({1'b0, pos_y_q}) + dy_s, YMAX_S);
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    moving_d = 1'b0;
    if (tick) begin
      pos_x_d = nx_s[CORDW-1:0];
      pos_y_d = ny_s[CORDW-1:0];
`ifdef SPRITE_WRAP_EN
      moving_d = (dx_s != '0) || (dy_s != '0);
`else
      moving_d = (nx_s[CORDW-1:0] != pos_x_q) || (ny_s[CORDW-1:0] != pos_y_q);
`endif
    end
  end

  // Position and moving registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q  <= X_RST;
      pos_y_q  <= Y_RST;
      moving_q <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      moving_q <= moving_d;
    end
  end

  // Render stages. The hit test uses wrapping unsigned subtraction, so pixels
  // left of or above the sprite wrap to large values and fail the compare.
  always_comb begin
    diff_x = sx - pos_x_q;
    diff_y = sy - pos_y_q;
    hit_d  = ({1'b0, diff_x} < SPR_W_U) && ({1'b0, diff_y} < SPR_H_U);
    rgb_d  = de1_q ? (hit_q ? FG : BG) : 6'b0;
  end

  // Pipeline registers: stage 1 holds hit/de, stage 2 holds the colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      de1_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hit_q <= hit_d;
      de1_q <= de;
      rgb_q <= rgb_d;
    end
  end

  assign rgb    = rgb_q;
  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Testbench for vga_sprite_ctrl. Two instances share the same inputs:
// u_dut uses 16x16 sprites and u_odd uses 17x17 sprites. Every output is compared
// on every cycle against a behavioural model of the screen, the buttons and the
// sprite rectangles. Hand-computed literal checks pin key points of the model.
module tb_vga_sprite_ctrl;
  localparam int         H_RES = 800, V_RES = 480, CORDW = 10, STEP = 2, DB_BITS = 4;
  localparam logic [5:0] FG = 6'b110000, BG = 6'b000011;
  // A level is adopted after 2 sync clocks plus 2^DB_BITS debounce clocks.
  localparam int SETTLE = 2 + (1 << DB_BITS);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             de;
  logic [CORDW-1:0] sx, sy;
  logic [3:0]       btn;
  logic [5:0]       rgb0, rgb1;
  logic [CORDW-1:0] px0, py0, px1, py1;
  logic             mv0, mv1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_sprite_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .CORDW(CORDW), .SPR_W(16), .SPR_H(16),
                    .STEP(STEP), .DB_BITS(DB_BITS), .FG(FG), .BG(BG)) u_dut (
    .clk(clk), .rst_n(rst_n), .de(de), .sx(sx), .sy(sy), .btn(btn),
    .rgb(rgb0), .pos_x(px0), .pos_y(py0), .moving(mv0));

  vga_sprite_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .CORDW(CORDW), .SPR_W(17), .SPR_H(17),
                    .STEP(STEP), .DB_BITS(DB_BITS), .FG(FG), .BG(BG)) u_odd (
    .clk(clk), .rst_n(rst_n), .de(de), .sx(sx), .sy(sy), .btn(btn),
    .rgb(rgb1), .pos_x(px1), .pos_y(py1), .moving(mv1));

  // ---------------- behavioural model ----------------
  int         spr_w [2] = '{16, 17};
  int         spr_h [2] = '{16, 17};
  int         m_x [2], m_y [2], m_mov [2];
  logic [5:0] m_rgb [2], m_pipe [2];
  logic [3:0] m_db, m_prev;
  int         run [4];
  bit         ready = 0;

  function automatic logic [5:0] colour(int k, int x, int y, logic d);
    if (!d) return 6'b0;
    if (x >= m_x[k] && x < m_x[k] + spr_w[k] && y >= m_y[k] && y < m_y[k] + spr_h[k])
      return FG;
    return BG;
  endfunction

  task automatic model_step();
    int dx, dy, nx, ny, xmax, ymax;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_x[k] = (H_RES - spr_w[k]) / 2;
        m_y[k] = (V_RES - spr_h[k]) / 2;
        m_mov[k] = 0; m_rgb[k] = 0; m_pipe[k] = 0;
      end
      m_db = 0; m_prev = 0;
      for (int b = 0; b < 4; b++) run[b] = 0;
      ready = 1;
      return;
    end
    // {right, left, down, up}: opposing presses cancel each other.
    dx = (m_db[3] && !m_db[2]) ? STEP : (m_db[2] && !m_db[3]) ? -STEP : 0;
    dy = (m_db[1] && !m_db[0]) ? STEP : (m_db[0] && !m_db[1]) ? -STEP : 0;
    for (int k = 0; k < 2; k++) begin
      m_rgb[k]  = m_pipe[k];
      m_pipe[k] = colour(k, int'(sx), int'(sy), de);
      m_mov[k]  = 0;
      if (sx == 0 && sy == V_RES) begin
        xmax = H_RES - spr_w[k];
        ymax = V_RES - spr_h[k];
        nx = m_x[k] + dx;
        ny = m_y[k] + dy;
`ifdef SPRITE_WRAP_EN
        if (nx < 0) nx += xmax + 1; else if (nx > xmax) nx -= xmax + 1;
        if (ny < 0) ny += ymax + 1; else if (ny > ymax) ny -= ymax + 1;
        m_mov[k] = (dx != 0 || dy != 0) ? 1 : 0;
`else
        nx = (nx < 0) ? 0 : (nx > xmax) ? xmax : nx;
        ny = (ny < 0) ? 0 : (ny > ymax) ? ymax : ny;
        m_mov[k] = (nx != m_x[k] || ny != m_y[k]) ? 1 : 0;
`endif
        m_x[k] = nx;
        m_y[k] = ny;
      end
    end
    // A raw level held for SETTLE consecutive clock edges becomes the pressed state.
    for (int b = 0; b < 4; b++) begin
      if (btn[b] != m_prev[b]) run[b] = 1;
      else if (run[b] < 1000) run[b]++;
      m_prev[b] = btn[b];
      if (run[b] >= SETTLE) m_db[b] = btn[b];
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every DUT output with the model on each falling edge.
  initial forever begin
    @(negedge clk);
    if (ready) begin
      check("rgb0", int'(rgb0), int'(m_rgb[0]));
      check("pos_x0", int'(px0), m_x[0]);
      check("pos_y0", int'(py0), m_y[0]);
      check("moving0", int'(mv0), m_mov[0]);
      check("rgb1", int'(rgb1), int'(m_rgb[1]));
      check("pos_x1", int'(px1), m_x[1]);
      check("pos_y1", int'(py1), m_y[1]);
      check("moving1", int'(mv1), m_mov[1]);
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input logic d);
    sx = CORDW'(x);
    sy = CORDW'(y);
    de = d;
  endtask

  task automatic idle();
    set_pix(10, 490, 1'b0);
  endtask

  task automatic tick();
    set_pix(0, V_RES, 1'b0);
    step();
    idle();
  endtask

  task automatic hold(input logic [3:0] b);
    btn = b;
    repeat (SETTLE + 2) step();
  endtask

  // Presents one pixel, then checks the colour that u_dut shows two clocks later.
  task automatic pixel(input string name, input int x, input int y, input logic d,
                       input logic [5:0] exp);
    set_pix(x, y, d);
    step();
    idle();
    step();
    check(name, int'(rgb0), int'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 4'b0;
    idle();
    repeat (3) step();
    check("reset rgb", int'(rgb0), 0);
    check("reset pos_x", int'(px0), 392);
    check("reset pos_y", int'(py0), 232);
    check("reset moving", int'(mv0), 0);
    rst_n = 1'b1;
    step();

    // Sprite covers x 392..407 and y 232..247.
    pixel("pix inside", 392, 232, 1'b1, FG);
    pixel("pix left", 391, 232, 1'b1, BG);
    pixel("pix blank", 392, 232, 1'b0, 6'b0);
    pixel("pix corner", 407, 247, 1'b1, FG);
    pixel("pix right", 408, 247, 1'b1, BG);
    pixel("pix below", 400, 248, 1'b1, BG);

    // Move right.
    hold(4'b1000);
    tick();
    check("right 1 pos_x", int'(px0), 394);
    check("right 1 moving", int'(mv0), 1);
    step();
    check("moving one cycle", int'(mv0), 0);
    repeat (5) tick();
    check("right 6 pos_x", int'(px0), 404);
    repeat (48) tick();
    check("right 54 pos_x", int'(px0), 500);
    check("odd right pos_x", int'(px1), 499);
    hold(4'b0000);

    // A glitch shorter than the debounce time is ignored.
    btn = 4'b0001;
    repeat (10) step();
    hold(4'b0000);
    tick();
    check("glitch pos_y", int'(py0), 232);
    check("glitch moving", int'(mv0), 0);

    // Opposing buttons cancel each other.
    hold(4'b0011);
    tick();
    check("opposed pos_y", int'(py0), 232);
    check("opposed moving", int'(mv0), 0);
    hold(4'b0000);

    // Reset in the middle of the frame.
    set_pix(50, 100, 1'b1);
    step();
    check("pre-reset pos_x", int'(px0), 500);
    rst_n = 1'b0;
    #1;
    check("async reset pos_x", int'(px0), 392);
    check("async reset rgb", int'(rgb0), 0);
    #1;
    rst_n = 1'b1;
    btn = 4'b1000;
    for (int i = 0; i < SETTLE + 4; i++) begin
      set_pix(0, 100 + i * 10, 1'b1);
      step();
    end
    set_pix(1, V_RES, 1'b0);
    step();
    set_pix(0, V_RES - 1, 1'b0);
    step();
    check("no early tick", int'(px0), 392);
    tick();
    check("first tick after reset", int'(px0), 394);

    // Left edge: u_odd reaches x=1 and u_dut reaches x=2, then both step to zero.
    hold(4'b0100);
    repeat (196) tick();
    check("edge odd pos_x", int'(px1), 1);
    check("edge dut pos_x", int'(px0), 2);
    tick();
    check("edge dut moving", int'(mv0), 1);
    check("edge odd moving", int'(mv1), 1);
`ifdef SPRITE_WRAP_EN
    check("wrap odd pos_x", int'(px1), 783);
`else
    check("clamp odd pos_x", int'(px1), 0);
    check("clamp dut pos_x", int'(px0), 0);
    tick();
    check("clamp hold pos_x", int'(px0), 0);
    check("clamp hold moving", int'(mv0), 0);
    check("clamp hold odd moving", int'(mv1), 0);
`endif

    // Bottom edge.
    hold(4'b0010);
    repeat (116) tick();
    check("bottom dut pos_y", int'(py0), 464);
    check("bottom odd pos_y", int'(py1), 463);
    tick();
`ifndef SPRITE_WRAP_EN
    check("bottom clamp pos_y", int'(py0), 464);
    check("bottom clamp moving", int'(mv0), 0);
`endif
    hold(4'b0000);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
